// File: rtl/pcie_dllp_tx_sched_pkg.sv
// ============================================================================
// Module   : pcie_dllp_tx_sched_pkg
// Brief    : DLLP type codes, packet layouts and field packers for DLLP TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_dllp_tx_sched_pkg;

    localparam logic [7:0]  c_dllp_ack       = 8'h00;
    localparam logic [7:0]  c_dllp_nak       = 8'h10;
    localparam logic [7:0]  c_dllp_updfc_p   = 8'h80;
    localparam logic [7:0]  c_dllp_updfc_np  = 8'h90;
    localparam logic [7:0]  c_dllp_updfc_cpl = 8'hA0;
    localparam logic [15:0] c_crc16_poly     = 16'h100B;
    localparam logic [15:0] c_crc16_seed     = 16'hFFFF;

    // Content bytes packed byte3..byte0, so byte0 (type) sits in [7:0].
    typedef struct packed {
        logic [7:0] seq_lo;
        logic [3:0] rsvd_b2;
        logic [3:0] seq_hi;
        logic [7:0] rsvd_b1;
        logic [7:0] dtype;
    } acknak_dllp_t;

    typedef struct packed {
        logic [7:0] data_lo;
        logic [1:0] hdr_lo;
        logic [1:0] data_scale;
        logic [3:0] data_hi;
        logic [1:0] hdr_scale;
        logic [5:0] hdr_hi;
        logic [7:0] dtype;
    } updfc_dllp_t;

    typedef struct packed {
        logic [15:0] rsvd;
        logic [15:0] crc;
        logic [31:0] content;
    } dllp_word_t;

    function automatic acknak_dllp_t make_acknak(input logic [7:0] dtype, input logic [11:0] seq);
        acknak_dllp_t p;
        p        = '0;
        p.dtype  = dtype;
        p.seq_hi = seq[11:8];
        p.seq_lo = seq[7:0];
        return p;
    endfunction

    function automatic updfc_dllp_t make_updfc(input logic [7:0] dtype, input logic [7:0] hdr,
                                               input logic [11:0] data);
        updfc_dllp_t p;
        p         = '0;
        p.dtype   = dtype;
        p.hdr_hi  = hdr[7:2];
        p.hdr_lo  = hdr[1:0];
        p.data_hi = data[11:8];
        p.data_lo = data[7:0];
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_dllp_tx_sched_crc16.sv
// ============================================================================
// Module   : pcie_dllp_crc16
// Brief    : Combinational DLLP CRC16 over the four content bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_dllp_crc16
    import pcie_dllp_tx_sched_pkg::*;
(
    input  logic [31:0] data,
    output logic [15:0] crc
);

    logic [15:0] w_lfsr;

    // Bits enter byte0 bit0 first; result is complemented and bit-reversed so
    // CRC bit 15 lands in byte4 bit 0.
    always_comb begin
        w_lfsr = c_crc16_seed;
        for (int i = 0; i < 32; i++) begin
            if (w_lfsr[15] ^ data[i]) begin
                w_lfsr = {w_lfsr[14:0], 1'b0} ^ c_crc16_poly;
            end else begin
                w_lfsr = {w_lfsr[14:0], 1'b0};
            end
        end
        crc = '0;
        for (int i = 0; i < 16; i++) begin
            crc[i] = ~w_lfsr[15-i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcie_dllp_tx_sched.sv
// ============================================================================
// Module   : pcie_dllp_tx_sched
// Brief    : Ack/Nak/UpdateFC DLLP scheduler with Ack coalescing and FC refresh.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_dllp_tx_sched
    import pcie_dllp_tx_sched_pkg::*;
#(
    parameter int         ACK_TIMER_CYCLES = 64,
    parameter int         FC_UPDATE_CYCLES = 256,
    parameter logic [2:0] VC_ID            = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dl_active_i,
    input  logic        ack_req_i,
    input  logic [11:0] ack_seq_i,
    input  logic        nak_req_i,
    input  logic [11:0] nak_seq_i,
    input  logic [2:0]  fc_upd_req_i,
    input  logic [23:0] fc_hdr_i,
    input  logic [35:0] fc_data_i,
    output logic        dllp_valid_o,
    output logic [63:0] dllp_o,
    input  logic        dllp_ready_i
);

    localparam int               c_ACK_W    = $clog2(ACK_TIMER_CYCLES);
    localparam int               c_FC_W     = $clog2(FC_UPDATE_CYCLES);
    localparam logic [c_ACK_W-1:0] c_ACK_LAST = c_ACK_W'(ACK_TIMER_CYCLES - 1);
    localparam logic [c_FC_W-1:0]  c_FC_LAST  = c_FC_W'(FC_UPDATE_CYCLES - 1);
    localparam logic [7:0]       c_vc_byte  = {5'b00000, VC_ID};

    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_t;

    out_state_t         r_state, w_state_nxt;
    logic               r_nak_pend, r_ack_pend;
    logic [2:0]         r_fc_pend;
    logic [11:0]        r_ack_seq, r_nak_seq;
    logic [c_ACK_W-1:0] r_ack_timer;
    logic [c_FC_W-1:0]  r_fc_timer;
    dllp_word_t         r_dllp;

    logic        w_ack_due, w_fc_wrap, w_launch, w_sel_nak, w_sel_ack, w_acknak_go;
    logic [2:0]  w_sel_fc, w_fc_clr;
    logic [31:0] w_content;
    logic [15:0] w_crc;

    // Timer saturates at expiry, so "due" holds until an Ack/Nak launch clears it.
    assign w_ack_due = r_ack_pend && (r_ack_timer == c_ACK_LAST);
    assign w_fc_wrap = (r_fc_timer == c_FC_LAST);

    always_comb begin
        w_sel_nak = 1'b0;
        w_sel_ack = 1'b0;
        w_sel_fc  = 3'b000;
        w_content = '0;
        if (r_nak_pend) begin
            w_sel_nak = 1'b1;
            w_content = make_acknak(c_dllp_nak, r_nak_seq);
        end else if (w_ack_due) begin
            w_sel_ack = 1'b1;
            w_content = make_acknak(c_dllp_ack, r_ack_seq);
        end else if (r_fc_pend[0]) begin
            w_sel_fc  = 3'b001;
            w_content = make_updfc(c_dllp_updfc_p | c_vc_byte, fc_hdr_i[7:0], fc_data_i[11:0]);
        end else if (r_fc_pend[1]) begin
            w_sel_fc  = 3'b010;
            w_content = make_updfc(c_dllp_updfc_np | c_vc_byte, fc_hdr_i[15:8], fc_data_i[23:12]);
        end else if (r_fc_pend[2]) begin
            w_sel_fc  = 3'b100;
            w_content = make_updfc(c_dllp_updfc_cpl | c_vc_byte, fc_hdr_i[23:16], fc_data_i[35:24]);
        end
    end

    assign w_launch    = dl_active_i && (w_sel_nak || w_sel_ack || (|w_sel_fc))
                         && ((r_state == ST_EMPTY) || dllp_ready_i);
    assign w_acknak_go = w_launch && (w_sel_nak || w_sel_ack);
    assign w_fc_clr    = w_launch ? w_sel_fc : 3'b000;

    pcie_dllp_crc16 u_crc (
        .data (w_content),
        .crc  (w_crc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_launch) w_state_nxt = ST_FULL;
            ST_FULL:  if (dllp_ready_i && !w_launch) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else if (!dl_active_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dllp <= '0;
        end else if (w_launch) begin
            r_dllp <= '{rsvd: 16'h0000, crc: w_crc, content: w_content};
        end
    end

    // A request in the launch cycle of its own flag wins, keeping it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nak_pend  <= 1'b0;
            r_ack_pend  <= 1'b0;
            r_fc_pend   <= 3'b000;
            r_ack_seq   <= '0;
            r_nak_seq   <= '0;
            r_ack_timer <= '0;
            r_fc_timer  <= '0;
        end else if (!dl_active_i) begin
            r_nak_pend  <= 1'b0;
            r_ack_pend  <= 1'b0;
            r_fc_pend   <= 3'b000;
            r_ack_timer <= '0;
            r_fc_timer  <= '0;
        end else begin
            if (nak_req_i) begin
                r_nak_pend <= 1'b1;
                r_nak_seq  <= nak_seq_i;
            end else if (w_launch && w_sel_nak) begin
                r_nak_pend <= 1'b0;
            end
            if (ack_req_i) begin
                r_ack_pend <= 1'b1;
                r_ack_seq  <= ack_seq_i;
            end else if (w_acknak_go) begin
                r_ack_pend <= 1'b0;
            end
            if (w_acknak_go) begin
                r_ack_timer <= '0;
            end else if (r_ack_pend && !w_ack_due) begin
                r_ack_timer <= r_ack_timer + 1'b1;
            end
            r_fc_pend  <= w_fc_wrap ? 3'b111 : ((r_fc_pend & ~w_fc_clr) | fc_upd_req_i);
            r_fc_timer <= w_fc_wrap ? '0 : r_fc_timer + 1'b1;
        end
    end

    assign dllp_valid_o = (r_state == ST_FULL);
    assign dllp_o       = r_dllp;

endmodule

`default_nettype wire

// File: tb/tb_pcie_dllp_tx_sched.sv
// ============================================================================
// Module   : tb_pcie_dllp_tx_sched
// Brief    : Directed self-checking bench for the DLLP TX scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcie_dllp_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dl_active_i = 1'b0;
    logic        ack_req_i = 1'b0;
    logic [11:0] ack_seq_i = '0;
    logic        nak_req_i = 1'b0;
    logic [11:0] nak_seq_i = '0;
    logic [2:0]  fc_upd_req_i = '0;
    logic [23:0] fc_hdr_i = '0;
    logic [35:0] fc_data_i = '0;
    logic        dllp_valid_o;
    logic [63:0] dllp_o;
    logic        dllp_ready_i = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcie_dllp_tx_sched #(
        .ACK_TIMER_CYCLES (64),
        .FC_UPDATE_CYCLES (256),
        .VC_ID            (3'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dl_active_i  (dl_active_i),
        .ack_req_i    (ack_req_i),
        .ack_seq_i    (ack_seq_i),
        .nak_req_i    (nak_req_i),
        .nak_seq_i    (nak_seq_i),
        .fc_upd_req_i (fc_upd_req_i),
        .fc_hdr_i     (fc_hdr_i),
        .fc_data_i    (fc_data_i),
        .dllp_valid_o (dllp_valid_o),
        .dllp_o       (dllp_o),
        .dllp_ready_i (dllp_ready_i)
    );

    // Reference CRC: poly 100Bh, seed FFFFh, byte0 bit0 first, output inverted and reversed.
    function automatic logic [15:0] crc_model(input logic [31:0] d);
        logic [15:0] c;
        logic [15:0] o;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (c[15] != d[i]) c = (c << 1) ^ 16'h100B;
            else               c = (c << 1);
        end
        for (int i = 0; i < 16; i++) o[i] = ~c[15-i];
        return o;
    endfunction

    function automatic logic [63:0] exp_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
        return {16'h0000, crc_model({b3, b2, b1, b0}), b3, b2, b1, b0};
    endfunction

    task automatic flush();
        @(negedge clk);
        dl_active_i = 1'b0;
        @(negedge clk);
        dl_active_i = 1'b1;
    endtask

    // Request pulses are dropped after one sampled edge; returns cycle index of first valid.
    task automatic wait_valid(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            ack_req_i    = 1'b0;
            nak_req_i    = 1'b0;
            fc_upd_req_i = 3'b000;
            if (dllp_valid_o) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (dllp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dllp_valid_o); end
        n_checks++; if (dllp_o !== 64'h0) begin n_fail++; $display("FAIL reset_dllp: got %h want 0", dllp_o); end
        @(negedge clk);
        rst_n = 1'b1;
        dl_active_i = 1'b1;
    endtask

    task automatic test_ack_coalesce();
        int n;
        int cnt;
        flush();
        dllp_ready_i = 1'b1;
        ack_seq_i = 12'h123;
        ack_req_i = 1'b1;
        wait_valid(100, n);
        n_checks++; if (n !== 65) begin n_fail++; $display("FAIL ack_latency: got %0d want 65", n); end
        n_checks++; if (dllp_o !== exp_word(8'h00, 8'h00, 8'h01, 8'h23)) begin n_fail++; $display("FAIL ack_word: got %h want %h", dllp_o, exp_word(8'h00, 8'h00, 8'h01, 8'h23)); end
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dllp_valid_o) cnt++;
        end
        n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL ack_single: got %0d extra valid cycles want 0", cnt); end
    endtask

    task automatic test_nak_preempt();
        int n;
        int cnt;
        flush();
        ack_seq_i = 12'h050;
        ack_req_i = 1'b1;
        @(negedge clk);
        ack_req_i = 1'b0;
        repeat (9) @(negedge clk);
        nak_seq_i = 12'h0FF;
        nak_req_i = 1'b1;
        wait_valid(10, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL nak_latency: got %0d want 2", n); end
        n_checks++; if (dllp_o !== exp_word(8'h10, 8'h00, 8'h00, 8'hFF)) begin n_fail++; $display("FAIL nak_word: got %h want %h", dllp_o, exp_word(8'h10, 8'h00, 8'h00, 8'hFF)); end
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dllp_valid_o) cnt++;
        end
        n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL nak_covers_ack: got %0d valid cycles want 0", cnt); end
    endtask

    task automatic test_fc_order();
        int n;
        flush();
        fc_hdr_i  = {8'h07, 8'h21, 8'h40};
        fc_data_i = {12'hABC, 12'h123, 12'h400};
        fc_upd_req_i = 3'b111;
        wait_valid(10, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL fc_latency: got %0d want 2", n); end
        n_checks++; if (dllp_o !== exp_word(8'h80, 8'h10, 8'h04, 8'h00)) begin n_fail++; $display("FAIL fc_p_word: got %h want %h", dllp_o, exp_word(8'h80, 8'h10, 8'h04, 8'h00)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp_word(8'h90, 8'h08, 8'h41, 8'h23)) begin n_fail++; $display("FAIL fc_np_word: got v=%b %h want v=1 %h", dllp_valid_o, dllp_o, exp_word(8'h90, 8'h08, 8'h41, 8'h23)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp_word(8'hA0, 8'h01, 8'hCA, 8'hBC)) begin n_fail++; $display("FAIL fc_cpl_word: got v=%b %h want v=1 %h", dllp_valid_o, dllp_o, exp_word(8'hA0, 8'h01, 8'hCA, 8'hBC)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b0) begin n_fail++; $display("FAIL fc_drain: got valid %b want 0", dllp_valid_o); end
    endtask

    task automatic test_stall();
        int n;
        flush();
        dllp_ready_i = 1'b0;
        fc_upd_req_i = 3'b001;
        wait_valid(10, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL stall_latency: got %0d want 2", n); end
        for (int k = 0; k < 20; k++) begin
            n_checks++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp_word(8'h80, 8'h10, 8'h04, 8'h00)) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h want v=1 %h", k, dllp_valid_o, dllp_o, exp_word(8'h80, 8'h10, 8'h04, 8'h00)); end
            @(negedge clk);
            if (k == 3) begin
                nak_seq_i = 12'h777;
                nak_req_i = 1'b1;
                fc_upd_req_i = 3'b100;
            end else begin
                nak_req_i = 1'b0;
                fc_upd_req_i = 3'b000;
            end
        end
        dllp_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp_word(8'h10, 8'h00, 8'h07, 8'h77)) begin n_fail++; $display("FAIL stall_nak: got v=%b %h want v=1 %h", dllp_valid_o, dllp_o, exp_word(8'h10, 8'h00, 8'h07, 8'h77)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp_word(8'hA0, 8'h01, 8'hCA, 8'hBC)) begin n_fail++; $display("FAIL stall_cpl: got v=%b %h want v=1 %h", dllp_valid_o, dllp_o, exp_word(8'hA0, 8'h01, 8'hCA, 8'hBC)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got valid %b want 0", dllp_valid_o); end
    endtask

    task automatic test_fc_refresh();
        int n;
        flush();
        dllp_ready_i = 1'b1;
        wait_valid(300, n);
        n_checks++; if (n !== 257) begin n_fail++; $display("FAIL refresh_time: got %0d want 257", n); end
        n_checks++; if (dllp_o !== exp_word(8'h80, 8'h10, 8'h04, 8'h00)) begin n_fail++; $display("FAIL refresh_p: got %h want %h", dllp_o, exp_word(8'h80, 8'h10, 8'h04, 8'h00)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp_word(8'h90, 8'h08, 8'h41, 8'h23)) begin n_fail++; $display("FAIL refresh_np: got v=%b %h want v=1 %h", dllp_valid_o, dllp_o, exp_word(8'h90, 8'h08, 8'h41, 8'h23)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b1 || dllp_o !== exp_word(8'hA0, 8'h01, 8'hCA, 8'hBC)) begin n_fail++; $display("FAIL refresh_cpl: got v=%b %h want v=1 %h", dllp_valid_o, dllp_o, exp_word(8'hA0, 8'h01, 8'hCA, 8'hBC)); end
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b0) begin n_fail++; $display("FAIL refresh_drain: got valid %b want 0", dllp_valid_o); end
    endtask

    task automatic test_link_down();
        int n;
        int cnt;
        flush();
        dllp_ready_i = 1'b0;
        ack_seq_i = 12'h321;
        ack_req_i = 1'b1;
        fc_upd_req_i = 3'b111;
        wait_valid(10, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL down_setup: got %0d want 2", n); end
        dl_active_i = 1'b0;
        @(negedge clk);
        n_checks++; if (dllp_valid_o !== 1'b0) begin n_fail++; $display("FAIL down_valid: got %b want 0", dllp_valid_o); end
        dl_active_i = 1'b1;
        dllp_ready_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dllp_valid_o) cnt++;
        end
        n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL down_flushed: got %0d valid cycles want 0", cnt); end
        nak_seq_i = 12'h001;
        nak_req_i = 1'b1;
        wait_valid(10, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL down_resume_lat: got %0d want 2", n); end
        n_checks++; if (dllp_o !== exp_word(8'h10, 8'h00, 8'h00, 8'h01)) begin n_fail++; $display("FAIL down_resume_word: got %h want %h", dllp_o, exp_word(8'h10, 8'h00, 8'h00, 8'h01)); end
    endtask

    task automatic test_async_reset();
        int n;
        flush();
        dllp_ready_i = 1'b0;
        fc_upd_req_i = 3'b010;
        wait_valid(10, n);
        n_checks++; if (n !== 2 || dllp_o !== exp_word(8'h90, 8'h08, 8'h41, 8'h23)) begin n_fail++; $display("FAIL arst_setup: got n=%0d %h want n=2 %h", n, dllp_o, exp_word(8'h90, 8'h08, 8'h41, 8'h23)); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dllp_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", dllp_valid_o); end
        n_checks++; if (dllp_o !== 64'h0) begin n_fail++; $display("FAIL arst_dllp: got %h want 0", dllp_o); end
        @(negedge clk);
        rst_n = 1'b1;
        dllp_ready_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ack_coalesce();
        test_nak_preempt();
        test_fc_order();
        test_stall();
        test_fc_refresh();
        test_link_down();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
